bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 69 ++++++
 rtl/bus_arbiter.sv | 88 ++++++++
 tb/tb_bus_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Four-master bus bundle between the masters and the arbiter.
// The slave modport is the arbiter's view; master is the masters' view.
interface bus_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              m0_request_;
  logic              m1_request_;
  logic              m2_request_;
  logic              m3_request_;
  logic              m0_grant_;
  logic              m1_grant_;
  logic              m2_grant_;
  logic              m3_grant_;
  logic [ADDR_W-1:0] m0_address;
  logic [ADDR_W-1:0] m1_address;
  logic [ADDR_W-1:0] m2_address;
  logic [ADDR_W-1:0] m3_address;
  logic              m0_address_strobe_;
  logic              m1_address_strobe_;
  logic              m2_address_strobe_;
  logic              m3_address_strobe_;
  logic              m0_read_write;
  logic              m1_read_write;
  logic              m2_read_write;
  logic              m3_read_write;
  logic [DATA_W-1:0] m0_write_data;
  logic [DATA_W-1:0] m1_write_data;
  logic [DATA_W-1:0] m2_write_data;
  logic [DATA_W-1:0] m3_write_data;
  logic [ADDR_W-1:0] slave_address;
  logic              slave_address_strobe_;
  logic              slave_read_write;
  logic [DATA_W-1:0] slave_write_data;

  modport master (
    output m0_request_, m1_request_,
           m2_request_, m3_request_,
    output m0_address, m1_address,
           m2_address, m3_address,
    output m0_address_strobe_, m1_address_strobe_,
           m2_address_strobe_, m3_address_strobe_,
    output m0_read_write, m1_read_write,
           m2_read_write, m3_read_write,
    output m0_write_data, m1_write_data,
           m2_write_data, m3_write_data,
    input  m0_grant_, m1_grant_,
           m2_grant_, m3_grant_,
    input  slave_address, slave_address_strobe_,
           slave_read_write, slave_write_data
  );

  modport slave (
    input  m0_request_, m1_request_,
           m2_request_, m3_request_,
    input  m0_address, m1_address,
           m2_address, m3_address,
    input  m0_address_strobe_, m1_address_strobe_,
           m2_address_strobe_, m3_address_strobe_,
    input  m0_read_write, m1_read_write,
           m2_read_write, m3_read_write,
    input  m0_write_data, m1_write_data,
           m2_write_data, m3_write_data,
    output m0_grant_, m1_grant_,
           m2_grant_, m3_grant_,
    output slave_address, slave_address_strobe_,
           slave_read_write, slave_write_data
  );
endinterface

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with parked grant.
// The owner keeps the bus while it requests; grant and mux follow owner.
module bus_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic          clock,
  input  logic          reset_,
  bus_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    OWN_M0,
    OWN_M1,
    OWN_M2,
    OWN_M3
  } owner_t;

  owner_t            owner;
  owner_t            owner_nxt;
  logic [3:0]        req;
  logic [1:0]        cand;
  logic              found;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;
  logic              stb_mux;
  logic              rw_mux;

  assign req = ~{bus.m3_request_, bus.m2_request_,
                 bus.m1_request_, bus.m0_request_};

  always_ff @(posedge clock) begin
    if (!reset_) owner <= OWN_M0;
    else         owner <= owner_nxt;
  end

  // Search owner+1..owner+3; nearest requester wins, else stay parked.
  always_comb begin
    owner_nxt = owner;
    found     = 1'b0;
    cand      = 2'd0;
    if (!req[owner]) begin
      for (int k = 1; k < 4; k++) begin
        cand = owner + 2'(k);
        if (!found && req[cand]) begin
          owner_nxt = owner_t'(cand);
          found     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    addr_mux = bus.m0_address;
    data_mux = bus.m0_write_data;
    stb_mux  = bus.m0_address_strobe_;
    rw_mux   = bus.m0_read_write;
    unique case (owner)
      OWN_M0: ;
      OWN_M1: begin
        addr_mux = bus.m1_address;
        data_mux = bus.m1_write_data;
        stb_mux  = bus.m1_address_strobe_;
        rw_mux   = bus.m1_read_write;
      end
      OWN_M2: begin
        addr_mux = bus.m2_address;
        data_mux = bus.m2_write_data;
        stb_mux  = bus.m2_address_strobe_;
        rw_mux   = bus.m2_read_write;
      end
      OWN_M3: begin
        addr_mux = bus.m3_address;
        data_mux = bus.m3_write_data;
        stb_mux  = bus.m3_address_strobe_;
        rw_mux   = bus.m3_read_write;
      end
    endcase
  end

  assign bus.slave_address         = addr_mux;
  assign bus.slave_write_data      = data_mux;
  assign bus.slave_address_strobe_ = stb_mux;
  assign bus.slave_read_write      = rw_mux;

  assign {bus.m3_grant_, bus.m2_grant_,
          bus.m1_grant_, bus.m0_grant_} =
         ~(4'b0001 << owner);
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table, corner sequences,
// and random traffic against a distance-based owner model.
module tb_bus_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;

  typedef struct {
    logic [3:0] req_n;
    int         exp_own;
  } vec_t;

  logic clock = 1'b0;
  logic reset_ = 1'b0;

  bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int mown = 0;

  logic [3:0]    m_req = 4'hf;
  logic [AW-1:0] m_addr [4];
  logic          m_stb  [4];
  logic          m_rw   [4];
  logic [DW-1:0] m_wd   [4];

  function automatic int next_owner(int cur, logic [3:0] rq_n);
    int best = cur;
    int bd = 4;
    for (int i = 0; i < 4; i++) begin
      if (!rq_n[i] && ((i - cur + 4) % 4) < bd) begin
        bd = (i - cur + 4) % 4;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] grants();
    return {bus.m3_grant_, bus.m2_grant_,
            bus.m1_grant_, bus.m0_grant_};
  endfunction

  function automatic logic [3:0] gexp(int o);
    logic [3:0] one = 4'b0001;
    return ~(one << o);
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    bus.m0_request_ = m_req[0];
    bus.m1_request_ = m_req[1];
    bus.m2_request_ = m_req[2];
    bus.m3_request_ = m_req[3];
    bus.m0_address = m_addr[0];
    bus.m1_address = m_addr[1];
    bus.m2_address = m_addr[2];
    bus.m3_address = m_addr[3];
    bus.m0_address_strobe_ = m_stb[0];
    bus.m1_address_strobe_ = m_stb[1];
    bus.m2_address_strobe_ = m_stb[2];
    bus.m3_address_strobe_ = m_stb[3];
    bus.m0_read_write = m_rw[0];
    bus.m1_read_write = m_rw[1];
    bus.m2_read_write = m_rw[2];
    bus.m3_read_write = m_rw[3];
    bus.m0_write_data = m_wd[0];
    bus.m1_write_data = m_wd[1];
    bus.m2_write_data = m_wd[2];
    bus.m3_write_data = m_wd[3];
  endtask

  task automatic check_all(string tag);
    chk({tag, "_grant"}, 64'(grants()), 64'(gexp(mown)));
    chk({tag, "_addr"}, 64'(bus.slave_address),
        64'(m_addr[mown]));
    chk({tag, "_stb"}, 64'(bus.slave_address_strobe_),
        64'(m_stb[mown]));
    chk({tag, "_rw"}, 64'(bus.slave_read_write),
        64'(m_rw[mown]));
    chk({tag, "_wd"}, 64'(bus.slave_write_data),
        64'(m_wd[mown]));
  endtask

  // Called at a negedge: check current state, then advance one edge.
  task automatic tick(string tag);
    drive();
    #1 check_all(tag);
    @(posedge clock);
    mown = reset_ ? next_owner(mown, m_req) : 0;
    @(negedge clock);
  endtask

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{4'b1111, 0};
    tbl[1]  = '{4'b1000, 0};
    tbl[2]  = '{4'b1001, 1};
    tbl[3]  = '{4'b1001, 1};
    tbl[4]  = '{4'b1011, 2};
    tbl[5]  = '{4'b0111, 3};
    tbl[6]  = '{4'b1010, 0};
    tbl[7]  = '{4'b0000, 0};
    tbl[8]  = '{4'b0001, 1};
    tbl[9]  = '{4'b0011, 2};
    tbl[10] = '{4'b0111, 3};
    tbl[11] = '{4'b1110, 0};
    tbl[12] = '{4'b1111, 0};
    tbl[13] = '{4'b1101, 1};
    tbl[14] = '{4'b1111, 1};
    tbl[15] = '{4'b0110, 3};

    for (int i = 0; i < 4; i++) begin
      m_addr[i] = AW'(32'h0100_0000 * (i + 1) + i);
      m_stb[i]  = i[0];
      m_rw[i]   = i[1];
      m_wd[i]   = 32'hA5A5_0000 + DW'(i);
    end
    m_addr[0] = 30'h0000_0123;

    reset_ = 1'b0;
    drive();
    @(posedge clock);
    @(negedge clock);
    mown = 0;
    check_all("reset");
    chk("reset_addr_const", 64'(bus.slave_address),
        64'h123);
    reset_ = 1'b1;

    for (int i = 0; i < 10; i++) tick("idle");
    chk("idle_m0_grant", 64'(bus.m0_grant_), 64'd0);

    for (int i = 0; i < 16; i++) begin
      m_req = tbl[i].req_n;
      tick("tblpre");
      chk($sformatf("tbl%0d_grant", i), 64'(grants()),
          64'(gexp(tbl[i].exp_own)));
    end

    m_req = 4'b1011;
    m_stb[2] = 1'b0;
    m_stb[0] = 1'b1;
    tick("to2");
    chk("own2_grant", 64'(bus.m2_grant_), 64'd0);
    reset_ = 1'b0;
    tick("rst_mid");
    reset_ = 1'b1;
    chk("rst_mid_m0", 64'(bus.m0_grant_), 64'd0);
    chk("rst_mid_stb", 64'(bus.slave_address_strobe_), 64'd1);
    tick("rst_after");

    m_req = 4'b1101;
    tick("to1");
    m_addr[1] = 30'h1000_0004;
    m_addr[3] = 30'h3FFF_FFFF;
    m_stb[3] = 1'b0;
    m_stb[1] = 1'b1;
    drive();
    #1;
    chk("m1_addr", 64'(bus.slave_address), 64'h1000_0004);
    chk("m1_stb_hi", 64'(bus.slave_address_strobe_), 64'd1);
    m_stb[1] = 1'b0;
    m_stb[3] = 1'b1;
    m_addr[3] = 30'h0;
    drive();
    #1;
    chk("m1_stb_lo", 64'(bus.slave_address_strobe_), 64'd0);
    chk("m1_addr2", 64'(bus.slave_address), 64'h1000_0004);
    tick("m1_hold");

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0) m_req[i] = ~m_req[i];
        m_addr[i] = AW'($urandom);
        m_stb[i]  = 1'($urandom);
        m_rw[i]   = 1'($urandom);
        m_wd[i]   = $urandom;
      end
      reset_ = ($urandom_range(0, 49) != 0);
      tick("rnd");
    end
    reset_ = 1'b1;
    tick("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
